// File: rtl/rlen_pkg.sv
// Shared types and burst-sizing helper for the DMA read partitioner.
package rlen_pkg;

    localparam int BL       = 16;
    localparam int BOUNDARY = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Beats in the next burst: min of max burst length, beats left, beats to 4 KB edge.
    function automatic logic [4:0] burst_beats(
        input logic [11:0]  addr_lo,
        input logic [31:0]  rem,
        input int unsigned  lsb
    );
        logic [12:0] to_bnd;
        logic [12:0] lim;
        to_bnd = (13'(BOUNDARY) - {1'b0, addr_lo}) >> lsb;
        lim    = 13'(BL);
        if (to_bnd < lim) lim = to_bnd;
        if (rem < {19'd0, lim}) lim = rem[12:0];
        return lim[4:0];
    endfunction

endpackage

// File: rtl/rlen_burst_calc.sv
// Combinational ARLEN for the next burst from the current address and beats remaining.
module rlen_burst_calc
    import rlen_pkg::*;
#(
    parameter int AXI_LW = 8,
    parameter int LSB    = 4,
    parameter int CW     = 28
)(
    input  logic [11:0]       addr_lo,
    input  logic [CW-1:0]     rem,
    output logic [AXI_LW-1:0] arlen
);

    logic [4:0] beats;

    always_comb begin
        beats = burst_beats(addr_lo, 32'(rem), LSB);
        arlen = AXI_LW'(beats) - AXI_LW'(1);
    end

endmodule

// File: rtl/rlen_partition.sv
// DMA read partitioner: splits a transfer into 4 KB-safe INCR bursts and streams R beats out.
module rlen_partition
    import rlen_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int AMI_OD     = 4,
    parameter int AXI_BYTES  = AXI_DW / 8
)(
    input  logic                  usr_clk,
    input  logic                  usr_reset_n,
    input  logic                  cfg_dmar_valid,
    output logic                  cfg_dmar_ready,
    input  logic [31:0]           cfg_dmar_sa,
    input  logic [31:0]           cfg_dmar_len,
    output logic [AXI_IW-1:0]     usr_arid,
    output logic [AXI_AW-1:0]     usr_araddr,
    output logic [AXI_LW-1:0]     usr_arlen,
    output logic [AXI_SW-1:0]     usr_arsize,
    output logic [AXI_BURSTW-1:0] usr_arburst,
    output logic                  usr_arvalid,
    input  logic                  usr_arready,
    input  logic [AXI_IW-1:0]     usr_rid,
    input  logic [AXI_DW-1:0]     usr_rdata,
    input  logic [AXI_RRESPW-1:0] usr_rresp,
    input  logic                  usr_rlast,
    input  logic                  usr_rvalid,
    output logic                  usr_rready,
    output logic [AXI_DW-1:0]     dmar_data,
    output logic                  dmar_last,
    output logic                  dmar_valid,
    input  logic                  dmar_ready,
    output logic                  dmar_err,
    output logic                  dmar_done
);

    localparam int L  = $clog2(AXI_BYTES);
    localparam int CW = 32 - L;
    localparam int OW = $clog2(AMI_OD + 1);

    state_t              state_reg;
    logic [AXI_AW-1:0]   addr_reg;
    logic [AXI_AW-1:0]   araddr_reg;
    logic [AXI_LW-1:0]   arlen_reg;
    logic [AXI_LW-1:0]   arlen_next;
    logic [CW-1:0]       ar_rem_reg;
    logic [CW-1:0]       r_rem_reg;
    logic [CW-1:0]       ar_step;
    logic [CW-1:0]       ar_rem_after;
    logic [CW-1:0]       cfg_beats;
    logic [OW-1:0]       outst_reg;
    logic                arvalid_reg;
    logic                err_reg;
    logic                done_reg;
    logic                busy;
    logic                cfg_hs;
    logic                ar_hs;
    logic                r_hs;
    logic                r_final;
    logic                unused_ok;

    assign unused_ok    = ^{usr_rid, cfg_dmar_sa, cfg_dmar_len};

    assign cfg_beats    = cfg_dmar_len[31:L];
    assign busy         = (state_reg != IDLE);
    assign cfg_dmar_ready = !busy;
    assign cfg_hs       = cfg_dmar_valid & cfg_dmar_ready;

    // R channel is a pure passthrough, gated only by being mid-transfer.
    assign usr_rready   = dmar_ready & busy;
    assign dmar_valid   = usr_rvalid & busy;
    assign dmar_data    = usr_rdata;
    assign dmar_last    = (r_rem_reg == CW'(1));
    assign r_hs         = usr_rvalid & usr_rready;
    assign r_final      = r_hs & dmar_last;

    assign ar_hs        = arvalid_reg & usr_arready;
    assign ar_step      = CW'(arlen_reg) + CW'(1);
    assign ar_rem_after = ar_rem_reg - ar_step;

    assign usr_arid     = AXI_IW'(1);
    assign usr_arsize   = AXI_SW'(L);
    assign usr_arburst  = AXI_BURSTW'(1);
    assign usr_araddr   = araddr_reg;
    assign usr_arlen    = arlen_reg;
    assign usr_arvalid  = arvalid_reg;
    assign dmar_err     = err_reg;
    assign dmar_done    = done_reg;

    rlen_burst_calc #(
        .AXI_LW (AXI_LW),
        .LSB    (L),
        .CW     (CW)
    ) u_calc (
        .addr_lo (addr_reg[11:0]),
        .rem     (ar_rem_reg),
        .arlen   (arlen_next)
    );

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            araddr_reg  <= '0;
            arlen_reg   <= '0;
            ar_rem_reg  <= '0;
            r_rem_reg   <= '0;
            outst_reg   <= '0;
            arvalid_reg <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_hs && cfg_beats != '0) begin
                        state_reg  <= BUSY;
                        addr_reg   <= {cfg_dmar_sa[AXI_AW-1:L], {L{1'b0}}};
                        ar_rem_reg <= cfg_beats;
                        r_rem_reg  <= cfg_beats;
                        outst_reg  <= '0;
                        err_reg    <= 1'b0;
                    end
                end
                default: begin
                    // One idle cycle after each AR handshake keeps araddr/arlen registered.
                    if (ar_hs) begin
                        arvalid_reg <= 1'b0;
                        addr_reg    <= addr_reg + (AXI_AW'(ar_step) << L);
                        ar_rem_reg  <= ar_rem_after;
                        if (ar_rem_after == '0) state_reg <= WAIT;
                    end else if (state_reg == BUSY && !arvalid_reg &&
                                 ar_rem_reg != '0 && outst_reg < OW'(AMI_OD)) begin
                        arvalid_reg <= 1'b1;
                        araddr_reg  <= addr_reg;
                        arlen_reg   <= arlen_next;
                    end

                    case ({ar_hs, r_hs & usr_rlast})
                        2'b10:   outst_reg <= outst_reg + OW'(1);
                        2'b01:   outst_reg <= outst_reg - OW'(1);
                        default: ;
                    endcase

                    if (r_hs) begin
                        r_rem_reg <= r_rem_reg - CW'(1);
                        if (usr_rresp != '0) err_reg <= 1'b1;
                    end

                    // Completion is driven only by the last data beat, whatever the AR side is doing.
                    if (r_final) begin
                        state_reg   <= IDLE;
                        arvalid_reg <= 1'b0;
                        ar_rem_reg  <= '0;
                        outst_reg   <= '0;
                        done_reg    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rlen_partition.sv
// Bench for rlen_partition: table of transfers against a behavioural AXI read slave, plus corner sequences.
module tb_rlen_partition;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int LW = 8;
    localparam int SW = 3;
    localparam int BW = 2;
    localparam int RW = 2;
    localparam int OD = 4;

    logic          usr_clk = 1'b0;
    logic          usr_reset_n = 1'b0;
    logic          cfg_dmar_valid = 1'b0;
    logic          cfg_dmar_ready;
    logic [31:0]   cfg_dmar_sa = '0;
    logic [31:0]   cfg_dmar_len = '0;
    logic [IW-1:0] usr_arid;
    logic [AW-1:0] usr_araddr;
    logic [LW-1:0] usr_arlen;
    logic [SW-1:0] usr_arsize;
    logic [BW-1:0] usr_arburst;
    logic          usr_arvalid;
    logic          usr_arready = 1'b1;
    logic [IW-1:0] usr_rid = '0;
    logic [DW-1:0] usr_rdata = '0;
    logic [RW-1:0] usr_rresp = '0;
    logic          usr_rlast = 1'b0;
    logic          usr_rvalid = 1'b0;
    logic          usr_rready;
    logic [DW-1:0] dmar_data;
    logic          dmar_last;
    logic          dmar_valid;
    logic          dmar_ready = 1'b1;
    logic          dmar_err;
    logic          dmar_done;

    always #5 usr_clk = ~usr_clk;

    rlen_partition #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
        .AXI_BURSTW(BW), .AXI_RRESPW(RW), .AMI_OD(OD)
    ) dut (
        .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
        .cfg_dmar_valid(cfg_dmar_valid), .cfg_dmar_ready(cfg_dmar_ready),
        .cfg_dmar_sa(cfg_dmar_sa), .cfg_dmar_len(cfg_dmar_len),
        .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen),
        .usr_arsize(usr_arsize), .usr_arburst(usr_arburst),
        .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
        .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp),
        .usr_rlast(usr_rlast), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
        .dmar_data(dmar_data), .dmar_last(dmar_last), .dmar_valid(dmar_valid),
        .dmar_ready(dmar_ready), .dmar_err(dmar_err), .dmar_done(dmar_done)
    );

    typedef struct packed {
        logic [31:0] sa;
        logic [31:0] len;
        logic [7:0]  n_ar;
        logic [31:0] first_addr;
        logic [7:0]  first_len;
        logic [31:0] last_addr;
        logic [7:0]  last_len;
        logic        bp;
    } vec_t;

    vec_t vecs [6];

    // Written only by the main test process
    int          checks = 0;
    int          errors = 0;
    int          xfer_ar_base = 0;
    int          beat_base = 0;
    int          done_base = 0;
    int          exp_beats = 0;
    logic [31:0] exp_base = '0;
    int          err_beat = -1;
    int          r_limit = -1;
    bit          ar_bp = 1'b0;
    bit          r_bp = 1'b0;
    logic [39:0] exp_ar_q [$];

    // Written only by the negedge monitor
    logic [39:0] ar_log [$];
    int          beat_total = 0;
    int          done_total = 0;
    int          data_bad = 0;
    int          last_bad = 0;
    int          gate_bad = 0;
    int          ar_unstable = 0;
    bit          r_hs_pend = 1'b0;
    bit          prev_pend = 1'b0;
    logic [39:0] prev_ar = '0;

    // Written only by the slave process
    int          slave_rd = 0;
    int          bursts_started = 0;
    bit          active = 1'b0;
    logic [31:0] cur_addr = '0;
    int          cur_left = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic void build_exp(input logic [31:0] sa, input logic [31:0] len);
        int a;
        int rem;
        int to_b;
        int n;
        exp_ar_q.delete();
        a   = int'(sa & ~32'hF);
        rem = int'(len >> 4);
        while (rem > 0) begin
            to_b = (4096 - (a & 32'hFFF)) / 16;
            n = 16;
            if (to_b < n) n = to_b;
            if (rem < n) n = rem;
            exp_ar_q.push_back({32'(a), 8'(n - 1)});
            a   = a + n * 16;
            rem = rem - n;
        end
    endfunction

    always @(negedge usr_clk) begin : monitor
        int idx;
        r_hs_pend = usr_rvalid & usr_rready;
        if (usr_reset_n) begin
            if (usr_rready !== (dmar_ready & !cfg_dmar_ready)) gate_bad++;
            if (dmar_valid !== (usr_rvalid & !cfg_dmar_ready)) gate_bad++;
            if (prev_pend && (!usr_arvalid || {usr_araddr, usr_arlen} != prev_ar)) ar_unstable++;
            prev_pend = usr_arvalid & !usr_arready;
            prev_ar   = {usr_araddr, usr_arlen};
            if (usr_arvalid && usr_arready) ar_log.push_back({usr_araddr, usr_arlen});
            if (dmar_valid && dmar_ready) begin
                idx = beat_total - beat_base;
                if (dmar_data !== {4{exp_base + 32'(idx) * 32'd16}}) data_bad++;
                if (dmar_last !== (idx == exp_beats - 1)) last_bad++;
                beat_total++;
            end
            if (dmar_done) done_total++;
        end else begin
            prev_pend = 1'b0;
        end
    end

    // AXI read slave: serves logged ARs in order; rvalid holds until taken.
    always @(posedge usr_clk) begin : slave
        logic [7:0] l;
        #1;
        if (!usr_reset_n) begin
            active     = 1'b0;
            usr_rvalid = 1'b0;
            usr_rlast  = 1'b0;
            slave_rd   = ar_log.size();
        end else begin
            if (r_hs_pend) begin
                cur_addr = cur_addr + 32'd16;
                cur_left--;
                if (cur_left == 0) active = 1'b0;
            end
            if (!active && slave_rd < ar_log.size() && (r_limit < 0 || bursts_started < r_limit)) begin
                {cur_addr, l} = ar_log[slave_rd];
                slave_rd++;
                cur_left = int'(l) + 1;
                active   = 1'b1;
                bursts_started++;
            end
            if (!(usr_rvalid && !r_hs_pend))
                usr_rvalid = active && (!r_bp || $urandom_range(0, 1) == 1);
            usr_rdata   = {4{cur_addr}};
            usr_rlast   = (cur_left == 1);
            usr_rresp   = (beat_total - beat_base == err_beat) ? 2'd2 : 2'd0;
            usr_arready = !ar_bp || ($urandom_range(0, 1) == 1);
            dmar_ready  = !r_bp || ($urandom_range(0, 3) != 0);
        end
    end

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] len);
        xfer_ar_base = ar_log.size();
        beat_base    = beat_total;
        done_base    = done_total;
        exp_base     = sa & ~32'hF;
        exp_beats    = int'(len >> 4);
        build_exp(sa, len);
        @(posedge usr_clk);
        #1;
        cfg_dmar_valid = 1'b1;
        cfg_dmar_sa    = sa;
        cfg_dmar_len   = len;
        @(negedge usr_clk);
        check("cfg_ready_idle", cfg_dmar_ready, 1'b1);
        @(posedge usr_clk);
        #1;
        cfg_dmar_valid = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int max_cyc, input bit exp_err);
        for (int c = 0; c < max_cyc && done_total == done_base; c++) @(negedge usr_clk);
        check("done_seen", done_total != done_base, 1'b1);
        repeat (3) @(negedge usr_clk);
        check("done_once", done_total - done_base, 1);
        check("beat_count", beat_total - beat_base, exp_beats);
        check("ar_count", ar_log.size() - xfer_ar_base, exp_ar_q.size());
        for (int i = 0; i < exp_ar_q.size(); i++)
            if (xfer_ar_base + i < ar_log.size())
                check("ar_addr_len", ar_log[xfer_ar_base + i], exp_ar_q[i]);
        check("err_flag", dmar_err, exp_err);
        check("ready_after", cfg_dmar_ready, 1'b1);
        check("data_order", data_bad, 0);
        check("last_flag", last_bad, 0);
        check("r_gating", gate_bad, 0);
        check("ar_stable", ar_unstable, 0);
        $display("xfer %s: sa=0x%0h beats=%0d ars=%0d err=%0b", tag, exp_base,
                 beat_total - beat_base, ar_log.size() - xfer_ar_base, dmar_err);
    endtask

    initial begin
        vecs[0] = '{32'h1000, 32'h400, 8'd4,  32'h1000, 8'd15, 32'h1300, 8'd15, 1'b0};
        vecs[1] = '{32'h1F80, 32'h200, 8'd3,  32'h1F80, 8'd7,  32'h2100, 8'd7,  1'b1};
        vecs[2] = '{32'h0000, 32'h010, 8'd1,  32'h0000, 8'd0,  32'h0000, 8'd0,  1'b0};
        vecs[3] = '{32'h2FF0, 32'h030, 8'd2,  32'h2FF0, 8'd0,  32'h3000, 8'd1,  1'b1};
        vecs[4] = '{32'h0105, 32'h05F, 8'd1,  32'h0100, 8'd4,  32'h0100, 8'd4,  1'b0};
        vecs[5] = '{32'h0800, 32'h1000, 8'd16, 32'h0800, 8'd15, 32'h1700, 8'd15, 1'b1};

        // Reset state
        #12;
        check("rst_cfg_ready", cfg_dmar_ready, 1'b1);
        check("rst_arvalid", usr_arvalid, 1'b0);
        check("rst_rready", usr_rready, 1'b0);
        check("rst_dmar_valid", dmar_valid, 1'b0);
        check("rst_err", dmar_err, 1'b0);
        check("rst_done", dmar_done, 1'b0);
        check("rst_araddr", usr_araddr, 32'h0);
        check("rst_arlen", usr_arlen, 8'h0);
        check("arid", usr_arid, 8'd1);
        check("arsize", usr_arsize, 3'd4);
        check("arburst", usr_arburst, 2'd1);
        @(negedge usr_clk);
        usr_reset_n = 1'b1;
        repeat (2) @(negedge usr_clk);

        for (int i = 0; i < 6; i++) begin
            ar_bp = vecs[i].bp;
            r_bp  = vecs[i].bp;
            start_xfer(vecs[i].sa, vecs[i].len);
            finish_xfer($sformatf("vec%0d", i), 3000, 1'b0);
            check("tbl_n_ar", ar_log.size() - xfer_ar_base, vecs[i].n_ar);
            if (ar_log.size() > xfer_ar_base) begin
                check("tbl_first_ar", ar_log[xfer_ar_base], {vecs[i].first_addr, vecs[i].first_len});
                check("tbl_last_ar", ar_log[ar_log.size() - 1], {vecs[i].last_addr, vecs[i].last_len});
            end
        end
        ar_bp = 1'b0;
        r_bp  = 1'b0;

        // Outstanding limit: no data returns, so only AMI_OD ARs may issue
        r_limit = bursts_started;
        start_xfer(32'h0, 32'h1000);
        repeat (40) @(negedge usr_clk);
        check("od_ar_count", ar_log.size() - xfer_ar_base, 4);
        check("od_arvalid_low", usr_arvalid, 1'b0);
        r_limit = bursts_started + 1;
        repeat (60) @(negedge usr_clk);
        check("od_ar_after_rlast", ar_log.size() - xfer_ar_base, 5);
        check("od_arvalid_low2", usr_arvalid, 1'b0);
        check("od_beats_one_burst", beat_total - beat_base, 16);
        r_limit = -1;
        finish_xfer("outstanding", 3000, 1'b0);

        // Zero beat count: handshake only
        xfer_ar_base = ar_log.size();
        done_base    = done_total;
        @(posedge usr_clk);
        #1;
        cfg_dmar_valid = 1'b1;
        cfg_dmar_sa    = 32'h100;
        cfg_dmar_len   = 32'hF;
        @(negedge usr_clk);
        check("zero_cfg_ready", cfg_dmar_ready, 1'b1);
        @(posedge usr_clk);
        #1;
        cfg_dmar_valid = 1'b0;
        repeat (8) @(negedge usr_clk);
        check("zero_ready_stays", cfg_dmar_ready, 1'b1);
        check("zero_no_ar", ar_log.size() - xfer_ar_base, 0);
        check("zero_no_done", done_total - done_base, 0);
        $display("xfer zero_len: no ARs expected, ars=%0d", ar_log.size() - xfer_ar_base);

        // Error response on first beat, sticky until next config
        err_beat = 0;
        start_xfer(32'h4000, 32'h20);
        finish_xfer("rresp_err", 500, 1'b1);
        repeat (5) @(negedge usr_clk);
        check("err_holds", dmar_err, 1'b1);
        err_beat = -1;
        start_xfer(32'h5000, 32'h10);
        finish_xfer("err_cleared", 500, 1'b0);

        // Reset while waiting on data
        r_limit = bursts_started;
        start_xfer(32'h3000, 32'h100);
        repeat (10) @(negedge usr_clk);
        check("wait_busy", cfg_dmar_ready, 1'b0);
        check("wait_arvalid", usr_arvalid, 1'b0);
        check("wait_araddr", usr_araddr, 32'h3000);
        #2;
        usr_reset_n = 1'b0;
        #1;
        check("mid_rst_cfg_ready", cfg_dmar_ready, 1'b1);
        check("mid_rst_arvalid", usr_arvalid, 1'b0);
        check("mid_rst_rready", usr_rready, 1'b0);
        check("mid_rst_dmar_valid", dmar_valid, 1'b0);
        check("mid_rst_done", dmar_done, 1'b0);
        check("mid_rst_araddr", usr_araddr, 32'h0);
        check("mid_rst_arlen", usr_arlen, 8'h0);
        $display("xfer reset_mid: abandoned sa=0x3000");
        repeat (3) @(negedge usr_clk);
        usr_reset_n = 1'b1;
        r_limit = -1;
        repeat (2) @(negedge usr_clk);
        start_xfer(vecs[0].sa, vecs[0].len);
        finish_xfer("after_reset", 3000, 1'b0);
        check("post_rst_first_ar", ar_log[xfer_ar_base], {vecs[0].first_addr, vecs[0].first_len});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rlen_partition.md
Name: rlen_partition

Overview:
DMA read-side partitioner, the read counterpart of the DMA write partitioner.
- Accepts one configuration at a time: start address plus length in bytes.
- Splits the transfer into INCR bursts of at most 16 beats, none crossing a 4 KB boundary, and issues them on the user AR channel.
- Streams the returned R beats to the DMA read data port, marking the final beat of the whole transfer.

Parameters:
AXI_DW, 128, data bus width
AXI_AW, 32, address width (<=32)
AXI_IW, 8, ID width
AXI_LW, 8, ARLEN width
AXI_SW, 3, ARSIZE width
AXI_BURSTW, 2, ARBURST width
AXI_RRESPW, 2, RRESP width
AMI_OD, 4, max outstanding AR bursts
AXI_BYTES, AXI_DW/8, bytes per beat (derived)

Ports:
usr_clk  in  1  clock
usr_reset_n  in  1  async active-low reset
cfg_dmar_valid  in  1  config request
cfg_dmar_ready  out  1  high in IDLE
cfg_dmar_sa  in  32  start byte address; low log2(AXI_BYTES) bits ignored
cfg_dmar_len  in  32  length in bytes; low log2(AXI_BYTES) bits ignored
usr_arid  out  AXI_IW  constant 1
usr_araddr  out  AXI_AW  burst address, beat-aligned
usr_arlen  out  AXI_LW  beats-1
usr_arsize  out  AXI_SW  constant log2(AXI_BYTES)
usr_arburst  out  AXI_BURSTW  constant 1 (INCR)
usr_arvalid  out  1  AR valid
usr_arready  in  1  AR ready
usr_rid  in  AXI_IW  ignored
usr_rdata  in  AXI_DW  read data
usr_rresp  in  AXI_RRESPW  response
usr_rlast  in  1  last beat of burst
usr_rvalid  in  1  R valid
usr_rready  out  1  R ready
dmar_data  out  AXI_DW  usr_rdata passthrough
dmar_last  out  1  final beat of entire transfer
dmar_valid  out  1  data valid
dmar_ready  in  1  downstream ready
dmar_err  out  1  sticky: any rresp!=0 seen in current transfer
dmar_done  out  1  one-cycle pulse when transfer completes

Behaviour:
- Reset values (async, usr_reset_n=0):
  - State IDLE; all counters 0.
  - cfg_dmar_ready=1; usr_arvalid=0; usr_rready=0; dmar_valid=0; dmar_err=0; dmar_done=0.
  - usr_araddr=0; usr_arlen=0.
- Reset mid-transfer: abandons the transfer immediately, with no flush.
- Length handling:
  - Beat count N = cfg_dmar_len[31:L], where L = log2(AXI_BYTES).
  - Config accepted on cfg_dmar_valid & cfg_dmar_ready.
  - N==0: handshake completes, no state change, no dmar_done.
  - N>0: latch address, ar_rem=N and r_rem=N; clear dmar_err; go to BUSY.
- Burst sizing: arlen+1 = min(16, ar_rem, beats to next 4 KB boundary), where beats to boundary = (4096 - addr[11:0]) >> L.
- usr_arvalid:
  - Asserted in BUSY while ar_rem>0 and outstanding<AMI_OD.
  - Registered: address and length are stable while valid is high and ready is low.
- On AR handshake:
  - Address advances by (arlen+1)<<L.
  - ar_rem decrements by arlen+1.
  - outstanding increments.
- Outstanding counter:
  - +1 on an AR handshake; -1 on an R handshake with usr_rlast.
  - Both in the same cycle: value unchanged.
- R path is combinational passthrough:
  - usr_rready = dmar_ready & (state!=IDLE).
  - dmar_valid = usr_rvalid & (state!=IDLE).
  - Zero added latency.
- On each R handshake:
  - r_rem decrements.
  - dmar_last = (r_rem==1).
  - rresp!=0 sets dmar_err.
- States:
  - IDLE -> BUSY on accepted config with N>0.
  - BUSY -> WAIT when ar_rem reaches 0.
  - WAIT -> IDLE on the R handshake with r_rem==1.
  - That final handshake pulses dmar_done on the next cycle; cfg_dmar_ready returns to 1 in the same cycle.
- If every AR is issued before data returns, BUSY and WAIT can complete in either order; completion is always gated on r_rem reaching 0.
- dmar_err holds until the next accepted config.
- Address wrap above 2^AXI_AW is not supported and is not checked.

Decomposition:
- Package rlen_pkg:
  - Constant BL=16.
  - Constant BOUNDARY=4096.
  - State enum {IDLE, BUSY, WAIT}.
  - Function burst_beats(addr, rem) returning the min of the three limits.
- Optional sub-module rlen_burst_calc: combinational, computing the next arlen from address and ar_rem.
- All other logic stays in the top module.

Test Plan:
- Plain transfer (AXI_DW=128): sa=0x1000, len=0x400 -> ARs (0x1000,15), (0x1100,15), (0x1200,15), (0x1300,15); 64 beats out; dmar_last only on beat 64; dmar_done pulses once.
- 4 KB crossing: sa=0x1F80, len=0x200 -> ARs (0x1F80,7), (0x2000,15), (0x2100,7); 32 beats out.
- Outstanding limit: arready=1 and rvalid held 0, len=0x1000 -> exactly 4 ARs issued, then arvalid low; a single rlast lets one more AR issue.
- Backpressure: dmar_ready toggled randomly -> usr_rready tracks dmar_ready exactly; no beats lost or duplicated; data order preserved.
- Zero length and error: cfg len=0xF -> cfg_dmar_ready stays 1, no AR issued. Then len=0x20 with rresp=2 on beat 1 -> dmar_err=1 until the next config.
- Reset mid-transfer: assert usr_reset_n=0 during WAIT -> all outputs return to reset values; a subsequent config runs correctly.
